// File: rtl/mips_mc_pkg.sv
// Shared types and ISA constants for the multi-cycle MIPS core.
package mips_mc_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_op_e;

    typedef enum logic [3:0] {
        ClsAlu,
        ClsImm,
        ClsLoad,
        ClsStore,
        ClsBeq,
        ClsBne,
        ClsJ,
        ClsJal,
        ClsJr,
        ClsIllegal
    } instr_cls_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnSlt   = 6'b101010;
    localparam logic [5:0] FnJr    = 6'b001000;

endpackage

// File: rtl/mips_mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port; r0 reads as zero.
module mips_mc_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned RAW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RAW-1:0]    raddr_a_i,
    input  logic [RAW-1:0]    raddr_b_i,
    input  logic              we_i,
    input  logic [RAW-1:0]    waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core with req/ack instruction and data memory ports.
// Define MIPS_MC_BNE_EN to decode opcode 000101 as bne; otherwise it is illegal.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned PC_INC   = 2,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic              instr_done_o,
    output logic              illegal_o
);

    localparam int unsigned SH  = $clog2(PC_INC);
    localparam int unsigned RAW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, alu_out_q, mdr_q;
    logic              imem_req_q, dmem_req_q, dmem_we_q, done_q, illegal_q;

    logic [5:0]        opcode, funct;
    instr_cls_e        cls;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] imm_s, imm_z, src_b, alu_res;
    logic [DATA_W-1:0] rf_a, rf_b, rf_wdata;
    logic [RAW-1:0]    rf_waddr;
    logic              rf_we;
    logic [ADDR_W-1:0] br_target, j_target, j_mask, j_index;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign imm_s  = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign imm_z  = {{(DATA_W-16){1'b0}}, ir_q[15:0]};

    always_comb begin
        cls    = ClsIllegal;
        alu_op = AluAdd;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnAdd: cls = ClsAlu;
                    FnSub: begin cls = ClsAlu; alu_op = AluSub; end
                    FnAnd: begin cls = ClsAlu; alu_op = AluAnd; end
                    FnOr:  begin cls = ClsAlu; alu_op = AluOr;  end
                    FnSlt: begin cls = ClsAlu; alu_op = AluSlt; end
                    FnJr:  cls = ClsJr;
                    default: ;
                endcase
            end
            OpLw:   cls = ClsLoad;
            OpSw:   cls = ClsStore;
            OpBeq:  begin cls = ClsBeq; alu_op = AluSub; end
`ifdef MIPS_MC_BNE_EN
            OpBne:  begin cls = ClsBne; alu_op = AluSub; end
`endif
            OpAddi: cls = ClsImm;
            OpSlti: begin cls = ClsImm; alu_op = AluSlt; end
            OpAndi: begin cls = ClsImm; alu_op = AluAnd; end
            OpOri:  begin cls = ClsImm; alu_op = AluOr;  end
            OpJ:    cls = ClsJ;
            OpJal:  cls = ClsJal;
            default: ;
        endcase
    end

    always_comb begin
        if (cls == ClsAlu || cls == ClsBeq || cls == ClsBne) begin
            src_b = b_q;
        end else if (opcode == OpAndi || opcode == OpOri) begin
            src_b = imm_z;
        end else begin
            src_b = imm_s;
        end
        case (alu_op)
            AluSub:  alu_res = a_q - src_b;
            AluAnd:  alu_res = a_q & src_b;
            AluOr:   alu_res = a_q | src_b;
            AluSlt:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(src_b))};
            default: alu_res = a_q + src_b;
        endcase
    end

    // pc_q already points past the current instruction when these are used.
    assign br_target = pc_q + (imm_s[ADDR_W-1:0] << SH);
    assign j_index   = ADDR_W'(ir_q[25:0]) << SH;
    assign j_mask    = {ADDR_W{1'b1}} << (26 + SH);
    assign j_target  = (pc_q & j_mask) | j_index;

    always_comb begin
        rf_we    = (state_q == StWb);
        rf_waddr = ir_q[16 +: RAW];
        rf_wdata = alu_out_q;
        case (cls)
            ClsAlu:  rf_waddr = ir_q[11 +: RAW];
            ClsLoad: rf_wdata = mdr_q;
            ClsJal: begin
                rf_waddr = RAW'(5'd31);
                rf_wdata = DATA_W'(pc_q);
            end
            default: ;
        endcase
    end

    mips_mc_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RAW      (RAW)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .raddr_a_i (ir_q[21 +: RAW]),
        .raddr_b_i (ir_q[16 +: RAW]),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_out_q  <= '0;
            mdr_q      <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                StFetch: begin
                    // First cycle after reset only raises the request.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack_i) begin
                        ir_q       <= imem_rdata_i;
                        pc_q       <= pc_q + ADDR_W'(PC_INC);
                        imem_req_q <= 1'b0;
                        state_q    <= StDecode;
                    end
                end
                StDecode: begin
                    a_q     <= rf_a;
                    b_q     <= rf_b;
                    state_q <= StExec;
                end
                StExec: begin
                    alu_out_q <= alu_res;
                    case (cls)
                        ClsLoad, ClsStore: begin
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= (cls == ClsStore);
                            state_q    <= StMem;
                        end
                        ClsAlu, ClsImm, ClsJal: state_q <= StWb;
                        default: begin
                            if ((cls == ClsBeq && a_q == b_q) || (cls == ClsBne && a_q != b_q)) begin
                                pc_q <= br_target;
                            end else if (cls == ClsJ) begin
                                pc_q <= j_target;
                            end else if (cls == ClsJr) begin
                                pc_q <= a_q[ADDR_W-1:0];
                            end
                            illegal_q  <= (cls == ClsIllegal);
                            done_q     <= 1'b1;
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end
                    endcase
                end
                StMem: begin
                    if (dmem_req_q && dmem_ack_i) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dmem_we_q) begin
                            done_q     <= 1'b1;
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end else begin
                            mdr_q   <= dmem_rdata_i;
                            state_q <= StWb;
                        end
                    end
                end
                StWb: begin
                    if (cls == ClsJal) begin
                        pc_q <= j_target;
                    end
                    done_q     <= 1'b1;
                    imem_req_q <= 1'b1;
                    state_q    <= StFetch;
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign imem_req_o   = imem_req_q;
    assign imem_addr_o  = pc_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = alu_out_q[ADDR_W-1:0];
    assign dmem_wdata_o = b_q;
    assign pc_o         = pc_q;
    assign alu_result_o = alu_out_q;
    assign instr_done_o = done_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: program table drives memories, retire/store scoreboards check.
module tb_mips_mc_core;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_nx;
        int          gap;
        bit          alu_chk;
        logic [31:0] alu;
        bit          ill;
        int          dly;
        logic [31:0] maddr;
        bit          st;
        logic [31:0] sdata;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_o, imem_ack_i, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic        instr_done_o, illegal_o;
    logic [31:0] imem_addr_o, imem_rdata_i, dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [31:0] pc_o, alu_result_o;

    int   n_total = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_done = 0;
    int   wcnt = 0;
    int   loop_hits = 0;
    bit   phase2 = 0;
    ent_t prog [64];
    ent_t cur;
    ent_t exp_q [$];
    st_t  st_q [$];
    logic [31:0] dmem [64];

    mips_mc_core #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .PC_INC   (2),
        .NUM_REGS (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .pc_o         (pc_o),
        .alu_result_o (alu_result_o),
        .instr_done_o (instr_done_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
        return {op, 26'(tgt)};
    endfunction

    // Table entry: instruction at pc and what its retirement must look like.
    task automatic put(input int pc, input logic [31:0] ins, input logic [31:0] pcn,
                       input int gap, input bit ac, input logic [31:0] alu, input bit ill,
                       input int dly, input logic [31:0] ma, input bit st,
                       input logic [31:0] sd);
        prog[pc >> 1] = '{ins, pcn, gap, ac, alu, ill, dly, ma, st, sd};
    endtask

    task automatic load_prog_a();
        put('h00, enc_i(6'h08, 0, 1, 5),       'h02, 0, 1, 5,            0, 0, 0, 0, 0);
        put('h02, enc_i(6'h08, 0, 2, -3),      'h04, 4, 1, 32'hFFFFFFFD, 0, 0, 0, 0, 0);
        put('h04, enc_r(1, 2, 3, 6'h20),       'h06, 4, 1, 2,            0, 0, 0, 0, 0);
        put('h06, enc_i(6'h2B, 0, 3, 8),       'h08, 4, 1, 8,            0, 0, 8, 1, 2);
        put('h08, enc_i(6'h23, 0, 4, 8),       'h0A, 8, 1, 8,            0, 3, 8, 0, 0);
        put('h0A, enc_i(6'h2B, 0, 4, 12),      'h0C, 5, 1, 12,           0, 1, 12, 1, 2);
        put('h0C, enc_r(2, 1, 5, 6'h2A),       'h0E, 4, 1, 1,            0, 0, 0, 0, 0);
        put('h0E, enc_i(6'h2B, 0, 5, 16),      'h10, 4, 1, 16,           0, 0, 16, 1, 1);
        put('h10, enc_i(6'h04, 1, 2, 5),       'h12, 3, 0, 0,            0, 0, 0, 0, 0);
        put('h12, 32'hFC000000,                'h14, 3, 0, 0,            1, 0, 0, 0, 0);
        put('h14, enc_i(6'h2B, 0, 1, 20),      'h16, 4, 1, 20,           0, 0, 20, 1, 5);
        put('h16, enc_j(6'h03, 'h20),          'h40, 4, 0, 0,            0, 0, 0, 0, 0);
        put('h40, enc_i(6'h2B, 0, 31, 24),     'h42, 4, 1, 24,           0, 0, 24, 1, 'h18);
        put('h42, enc_r(1, 2, 6, 6'h22),       'h44, 4, 1, 8,            0, 0, 0, 0, 0);
        put('h44, enc_r(1, 2, 7, 6'h24),       'h46, 4, 1, 5,            0, 0, 0, 0, 0);
        put('h46, enc_r(1, 2, 8, 6'h25),       'h48, 4, 1, 32'hFFFFFFFD, 0, 0, 0, 0, 0);
        put('h48, enc_i(6'h0A, 2, 9, -2),      'h4A, 4, 1, 1,            0, 0, 0, 0, 0);
        put('h4A, enc_i(6'h0C, 2, 10, 'hFFFF), 'h4C, 4, 1, 'hFFFD,       0, 0, 0, 0, 0);
        put('h4C, enc_i(6'h0D, 0, 11, 'h8000), 'h4E, 4, 1, 'h8000,       0, 0, 0, 0, 0);
        put('h4E, enc_r(31, 0, 0, 6'h08),      'h18, 3, 0, 0,            0, 0, 0, 0, 0);
        put('h18, enc_j(6'h02, 'h28),          'h50, 3, 0, 0,            0, 0, 0, 0, 0);
        // Never acknowledged: the core is reset while this store waits.
        put('h50, enc_i(6'h2B, 0, 1, 32),      'h52, 4, 1, 32,           0, -1, 32, 1, 5);
    endtask

    task automatic load_prog_b();
        put('h00, enc_i(6'h08, 0, 1, 1),       'h02, 0, 1, 1,            0, 0, 0, 0, 0);
`ifdef MIPS_MC_BNE_EN
        put('h02, enc_i(6'h05, 1, 0, 1),       'h06, 3, 0, 0,            0, 0, 0, 0, 0);
        put('h06, enc_i(6'h2B, 0, 3, 28),      'h08, 4, 1, 28,           0, 0, 28, 1, 0);
`else
        put('h02, enc_i(6'h05, 1, 0, 1),       'h04, 3, 0, 0,            1, 0, 0, 0, 0);
        put('h06, enc_i(6'h2B, 0, 3, 28),      'h08, 4, 1, 28,           0, 0, 28, 1, 7);
`endif
        put('h04, enc_i(6'h08, 0, 3, 7),       'h06, 4, 1, 7,            0, 0, 0, 0, 0);
        put('h08, enc_i(6'h04, 0, 0, -1),      'h08, 3, 0, 0,            0, 0, 0, 0, 0);
    endtask

    // Memory models and scoreboards, all sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        ent_t e;
        st_t  s;
        cyc++;
        if (reset) begin
            imem_ack_i = 1'b1;
            dmem_ack_i = 1'b1;
            wcnt = 0;
        end else begin
            if (instr_done_o) begin
                if (exp_q.size() == 0) begin
                    check("retire_unexpected", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("retire_pc", pc_o, e.pc_nx);
                    if (e.gap > 0) check("retire_gap", 32'(cyc - last_done), 32'(e.gap));
                    if (e.alu_chk) check("retire_alu", alu_result_o, e.alu);
                    check("retire_illegal", 32'(illegal_o), 32'(e.ill));
                end
                last_done = cyc;
                if (phase2 && pc_o == 32'h08) loop_hits++;
            end
            if (imem_req_o) begin
                e = prog[imem_addr_o[6:1]];
                imem_ack_i   = 1'b1;
                imem_rdata_i = e.instr;
                exp_q.push_back(e);
                if (e.st) st_q.push_back('{e.maddr, e.sdata});
                cur  = e;
                wcnt = 0;
            end else begin
                imem_ack_i   = 1'($urandom_range(0, 1));
                imem_rdata_i = $urandom;
            end
            if (dmem_req_o) begin
                check("dmem_addr", dmem_addr_o, cur.maddr);
                check("dmem_we", 32'(dmem_we_o), 32'(cur.st));
                if (cur.dly >= 0 && wcnt >= cur.dly) begin
                    dmem_ack_i = 1'b1;
                    wcnt = 0;
                    if (dmem_we_o) begin
                        if (st_q.size() == 0) begin
                            check("store_unexpected", 32'(st_q.size()), 1);
                        end else begin
                            s = st_q.pop_front();
                            check("store_addr", dmem_addr_o, s.addr);
                            check("store_data", dmem_wdata_o, s.data);
                        end
                        dmem[dmem_addr_o[7:2]] = dmem_wdata_o;
                    end else begin
                        dmem_rdata_i = dmem[dmem_addr_o[7:2]];
                    end
                end else begin
                    dmem_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                dmem_ack_i   = 1'($urandom_range(0, 1));
                dmem_rdata_i = $urandom;
            end
        end
    end

    initial begin
        repeat (4000) @(posedge clk);
        check("watchdog", 0, 1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        int stall;
        for (int i = 0; i < 64; i++) begin
            dmem[i] = '0;
            prog[i] = '{32'hFC000000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        end
        imem_ack_i = 0; dmem_ack_i = 0; imem_rdata_i = 0; dmem_rdata_i = 0;
        load_prog_a();
        #1 reset = 1'b1;
        #1;
        check("rst_pc", pc_o, 0);
        check("rst_imem_req", 32'(imem_req_o), 0);
        check("rst_dmem_req", 32'(dmem_req_o), 0);
        check("rst_alu", alu_result_o, 0);
        check("rst_pulses", {30'd0, instr_done_o, illegal_o}, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        stall = 0;
        for (int i = 0; i < 600 && stall < 3; i++) begin
            @(posedge clk);
            #2;
            if (dmem_req_o && dmem_addr_o == 32'd32) stall++;
        end
        check("stall_reached", 32'(stall), 3);

        // Asynchronous reset in the middle of a stalled store.
        reset = 1'b1;
        #1;
        check("abort_dmem_req", 32'(dmem_req_o), 0);
        check("abort_pc", pc_o, 0);
        check("abort_done", 32'(instr_done_o), 0);
        check("abort_pending_store", 32'(st_q.size()), 1);
        exp_q.delete();
        st_q.delete();
        phase2 = 1;
        load_prog_b();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 300 && loop_hits < 2; i++) @(posedge clk);
        check("self_loop_hits", 32'(loop_hits), 2);
        check("stores_drained", 32'(st_q.size()), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
